// File: rtl/vram_pkg.sv
// Shared types and constants for the video RAM arbiter.
package vram_pkg;

   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned STALL_W    = 16;

   // Video RAM window base; requesters apply it, the arbiter only muxes.
   localparam logic [15:0] VRAM_BASE = 16'h8000;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StAck  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, the CPU uses a req/ack handshake.
// Optional VRAM_STALL_CNT_EN adds a saturating count of CPU stall cycles.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               vid_req,
   input  logic [ADDR_W-1:0]  vid_a,
   output logic [DATA_W-1:0]  vid_q,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_a,
   input  logic [DATA_W-1:0]  cpu_d,
   output logic [DATA_W-1:0]  cpu_q,
   output logic               cpu_ack,
`ifdef VRAM_STALL_CNT_EN
   input  logic               stall_clr,
   output logic [STALL_W-1:0] stall_cnt,
`endif
   output logic [ADDR_W-1:0]  mem_a,
   output logic [DATA_W-1:0]  mem_d,
   output logic               mem_we,
   input  logic [DATA_W-1:0]  mem_q
);

   arb_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] cpu_q_d;
   logic              cpu_ack_d;
   logic              cpu_issue;

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      cpu_q_d   = cpu_q;
      cpu_ack_d = 1'b0;
      cpu_issue = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_req && !vid_req) begin
               cpu_issue = 1'b1;
               we_d      = cpu_we;
               state_d   = StWait;
            end
         end
         StWait: begin
            // RAM output now holds the data for the address issued last cycle.
            if (!we_q) cpu_q_d = mem_q;
            cpu_ack_d = 1'b1;
            state_d   = StAck;
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_a  = vid_a;
      mem_d  = cpu_d;
      mem_we = 1'b0;
      if (cpu_issue) begin
         mem_a  = cpu_a;
         mem_we = cpu_we & reset_n;
      end
   end

   assign vid_q = mem_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         cpu_q   <= '0;
         cpu_ack <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         cpu_q   <= cpu_q_d;
         cpu_ack <= cpu_ack_d;
      end
   end

`ifdef VRAM_STALL_CNT_EN
   logic stall_evt;
   assign stall_evt = (state_q == StIdle) && cpu_req && vid_req;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (stall_evt && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed cases plus randomized scanout traffic.
// Also exercises the stall counter when built with VRAM_STALL_CNT_EN.
module tb_vram_arbiter;
   import vram_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        vid_req, cpu_req, cpu_we, cpu_ack, mem_we;
   logic [15:0] vid_a, cpu_a, mem_a;
   logic [7:0]  vid_q, cpu_d, cpu_q, mem_d, mem_q;
`ifdef VRAM_STALL_CNT_EN
   logic        stall_clr = 1'b0;
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   vram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .vid_req  (vid_req),
      .vid_a    (vid_a),
      .vid_q    (vid_q),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_a    (cpu_a),
      .cpu_d    (cpu_d),
      .cpu_q    (cpu_q),
      .cpu_ack  (cpu_ack),
`ifdef VRAM_STALL_CNT_EN
      .stall_clr(stall_clr),
      .stall_cnt(stall_cnt),
`endif
      .mem_a    (mem_a),
      .mem_d    (mem_d),
      .mem_we   (mem_we),
      .mem_q    (mem_q)
   );

   // Registered single-port RAM, preloaded on the first clock edge.
   logic [7:0] ram [0:65535];
   logic       ram_init = 1'b0;

   function automatic logic [7:0] init_val(input int i);
      if (i == 'h8001) return 8'h17;
      return 8'(i ^ (i >> 8) ^ 'h5A);
   endfunction

   always @(posedge clock) begin
      if (!ram_init) begin
         for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
         ram_init <= 1'b1;
      end else if (mem_we) begin
         ram[mem_a] <= mem_d;
      end
      mem_q <= ram[mem_a];
   end

   // Reference model: memory contents as seen after each completed CPU access.
   logic [7:0] model_mem [0:65535];

   typedef struct {
      logic        we;
      logic [15:0] a;
      logic [7:0]  data;
      int          start;
      int          exact_ack;
      int          max_lat;
   } cpu_exp_t;

   cpu_exp_t   cpu_sb[$];
   logic [7:0] vid_sb[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none at cycle %0d", name, cyc);
   endtask

   // Monitor: compares DUT outputs against queued expectations.
   logic vid_prev = 1'b0;
   always @(negedge clock) begin
      cpu_exp_t e;
      logic [7:0] ve;
      if (vid_prev) begin
         if (vid_sb.size() == 0) fail("vid_unexpected");
         else begin
            ve = vid_sb.pop_front();
            chk("vid_q", 32'(vid_q), 32'(ve));
         end
      end
      vid_prev <= vid_req;
      if (vid_req) begin
         chk("vid_mem_a", 32'(mem_a), 32'(vid_a));
         chk("vid_mem_we", 32'(mem_we), 0);
      end
      if (cpu_ack) begin
         if (cpu_sb.size() == 0) fail("cpu_unexpected_ack");
         else begin
            e = cpu_sb.pop_front();
            if (!e.we) chk("cpu_q", 32'(cpu_q), 32'(e.data));
            if (e.exact_ack >= 0) chk("cpu_ack_cycle", cyc, e.exact_ack);
            else begin
               chk("cpu_ack_lat_max", 32'((cyc - e.start) <= e.max_lat), 1);
               chk("cpu_ack_lat_min", 32'((cyc - e.start) >= 2), 1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_vid(input logic r, input logic [15:0] a);
      vid_req = r;
      vid_a   = a;
      if (r) vid_sb.push_back(model_mem[a]);
   endtask

   task automatic start_cpu(input logic we, input logic [15:0] a, input logic [7:0] d,
                            input int exact, input int maxl);
      cpu_exp_t e;
      cpu_req     = 1'b1;
      cpu_we      = we;
      cpu_a       = a;
      cpu_d       = d;
      e.we        = we;
      e.a         = a;
      e.data      = we ? d : model_mem[a];
      e.start     = cyc;
      e.exact_ack = (exact < 0) ? -1 : cyc + exact;
      e.max_lat   = maxl;
      if (we) model_mem[a] = d;
      cpu_sb.push_back(e);
   endtask

   // Hold the request through the ack cycle, then release it.
   task automatic finish_cpu(input int budget);
      int n = 0;
      while (!cpu_ack && n < budget) begin
         tick();
         n++;
      end
      if (!cpu_ack) begin
         fail("cpu_ack_timeout");
         cpu_sb.delete();
      end
      tick();
      cpu_req = 1'b0;
   endtask

   initial begin
      logic ack_prev;
      logic w;
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) model_mem[i] = init_val(i);
      vid_req = 1'b0;
      vid_a   = '0;
      cpu_req = 1'b1;
      cpu_we  = 1'b1;
      cpu_a   = 16'h8000;
      cpu_d   = 8'hEE;

      // Reset holds outputs quiet even with a write request pending.
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_cpu_q", 32'(cpu_q), 0);
      cpu_req = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Lone write.
      start_cpu(1'b1, 16'h8000, 8'h41, 2, 0);
      @(negedge clock);
      chk("wr_mem_we", 32'(mem_we), 1);
      chk("wr_mem_a", 32'(mem_a), 32'h8000);
      chk("wr_mem_d", 32'(mem_d), 32'h41);
      finish_cpu(10);

      // Lone read of preloaded location.
      start_cpu(1'b0, 16'h8001, 8'h00, 2, 0);
      @(negedge clock);
      chk("rd_mem_we", 32'(mem_we), 0);
      finish_cpu(10);

      // Read back the written byte via scanout and via CPU.
      set_vid(1'b1, 16'h8000);
      tick();
      set_vid(1'b0, 16'h0000);
      start_cpu(1'b0, 16'h8000, 8'h00, 2, 0);
      finish_cpu(10);

      // Collision: video wins, CPU granted one cycle later.
      set_vid(1'b1, 16'h8010);
      start_cpu(1'b0, 16'h8002, 8'h00, 3, 0);
      @(negedge clock);
      chk("col_mem_a", 32'(mem_a), 32'h8010);
      chk("col_mem_we", 32'(mem_we), 0);
      tick();
      set_vid(1'b0, 16'h0000);
      @(negedge clock);
      chk("col_grant_a", 32'(mem_a), 32'h8002);
      finish_cpu(10);

      // Reset while the access is in WAIT: no ack, next access normal.
      cpu_req = 1'b1;
      cpu_we  = 1'b0;
      cpu_a   = 16'h8003;
      tick();
      reset_n = 1'b0;
      #1;
      chk("rstw_ack_now", 32'(cpu_ack), 0);
      cpu_req = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("rstw_no_ack", 32'(cpu_ack), 0);
         tick();
      end
      start_cpu(1'b0, 16'h8003, 8'h00, 2, 0);
      @(negedge clock);
      chk("rstw_regrant_a", 32'(mem_a), 32'h8003);
      finish_cpu(10);

`ifdef VRAM_STALL_CNT_EN
      @(negedge clock);
      chk("stall_start", 32'(stall_cnt), 0);
      tick();
      start_cpu(1'b0, 16'h8004, 8'h00, 7, 0);
      for (int k = 0; k < 5; k++) begin
         set_vid(1'b1, 16'h8020 + 16'(k));
         tick();
      end
      set_vid(1'b0, 16'h0000);
      finish_cpu(10);
      @(negedge clock);
      chk("stall_cnt5", 32'(stall_cnt), 5);
      tick();
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      @(negedge clock);
      chk("stall_clr", 32'(stall_cnt), 0);
      tick();
      start_cpu(1'b0, 16'h8005, 8'h00, -1, 70100);
      for (int k = 0; k < 70000; k++) begin
         set_vid(1'b1, 16'h8030);
         tick();
      end
      set_vid(1'b0, 16'h0000);
      @(negedge clock);
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
      finish_cpu(10);
`endif

      // Scanout pattern: strobes at x=5,6 of every 8 with random CPU traffic.
      ack_prev = 1'b0;
      for (int x = 0; x < 640; x++) begin
         if (cpu_req && ack_prev) cpu_req = 1'b0;
         if (!cpu_req && $urandom_range(0, 3) != 0) begin
            w = 1'($urandom_range(0, 1));
            if (w) a = 16'h8100 + 16'($urandom_range(0, 255));
            else a = 16'h8000 + 16'($urandom_range(0, 511));
            start_cpu(w, a, 8'($urandom), -1, 4);
         end
         ack_prev = cpu_ack;
         if ((x % 8) == 5 || (x % 8) == 6) set_vid(1'b1, 16'h8000 + 16'($urandom_range(0, 255)));
         else set_vid(1'b0, 16'h0000);
         tick();
      end
      set_vid(1'b0, 16'h0000);
      if (cpu_req && ack_prev) cpu_req = 1'b0;
      else if (cpu_req) finish_cpu(10);
      repeat (3) tick();

      chk("cpu_sb_empty", 32'(cpu_sb.size()), 0);
      chk("vid_sb_empty", 32'(vid_sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM between the text-mode scanout (video fetch) and the CPU bus.
- Scanout has absolute priority and fixed 1-cycle read latency, so character/attribute fetches are never disturbed.
- The CPU gets a req/ack handshake and is stalled only in cycles where scanout owns the port.
- Sits between the CPU bus decoder, the video generator and the 32K video RAM block.

Parameters:
- ADDR_W, 16, width of memory address for both requesters
- DATA_W, 8, memory data width

Ports:
- clock  in  1  system clock (25 MHz pixel clock domain)
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  scanout read strobe for this cycle
- vid_a  in  ADDR_W  scanout address, valid when vid_req=1
- vid_q  out  DATA_W  scanout read data, valid the cycle after vid_req
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
- cpu_a  in  ADDR_W  CPU address; stable while cpu_req=1
- cpu_d  in  DATA_W  CPU write data
- cpu_q  out  DATA_W  CPU read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- mem_a  out  ADDR_W  RAM address
- mem_d  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data, registered in RAM (1-cycle latency)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset values:
  - FSM=IDLE, cpu_ack=0, cpu_q=0.
  - mem_we forced 0 while reset_n=0.
- Port ownership (combinational, per cycle):
  - vid_req=1: mem_a=vid_a, mem_we=0. Video always wins.
  - else FSM=IDLE and cpu_req=1: CPU issue cycle. mem_a=cpu_a, mem_d=cpu_d, mem_we=cpu_we.
  - else: mem_a=vid_a, mem_we=0 (idle, harmless read).
- vid_q = mem_q passthrough. Read data appears exactly 1 cycle after vid_req, independent of CPU activity.
- FSM states and transitions:
  - IDLE:
    - cpu_req=1 and vid_req=0: issue CPU access, go WAIT.
    - cpu_req=1 and vid_req=1: stall, stay IDLE.
    - cpu_req=0: stay IDLE.
  - WAIT: cpu_q <= mem_q (read; write leaves cpu_q unchanged), cpu_ack <= 1, go ACK. Port is free for video in this cycle.
  - ACK: cpu_ack=1 visible, cpu_ack <= 0, go IDLE. Port is free for video.
- CPU latency: grant cycle N, cpu_ack high in cycle N+2, earliest next grant N+3.
- Writes take effect in the grant cycle. Ack timing is identical for reads and writes.
- Handshake rules:
  - The requester must keep cpu_a/cpu_we/cpu_d stable from cpu_req rise until the ack cycle.
  - cpu_req still high in the cycle after ack means a new (back-to-back) transaction.
  - cpu_req dropping before ack is a protocol error. The access in flight still completes and acks.
- Continuous vid_req starves the CPU indefinitely. This is permitted: scanout issues at most 2 strobes per 8 pixels, so worst-case CPU wait is 2 cycles.
- Reset mid-operation: FSM returns to IDLE and cpu_ack clears immediately. An in-flight access is dropped with no ack. A write already issued in its grant cycle is not undone.
- Width rule: mem_a/mem_d are straight muxes with no arithmetic. Windowing (0x8000 base) is the requester's job.

Optional Feature:
- Macro: VRAM_STALL_CNT_EN.
- Enabled:
  - Adds output stall_cnt [15:0], a saturating count (stops at 0xFFFF) of cycles spent in IDLE with cpu_req=1 and vid_req=1.
  - Adds input stall_clr, a synchronous clear that overrides increment.
  - stall_cnt resets to 0.
- Disabled: ports and counter absent. Functional behaviour otherwise identical.

Decomposition:
- Shared package vram_pkg:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, ACK=2'd2.
  - VRAM_BASE=16'h8000.
  - Default ADDR_W/DATA_W.
- No sub-module needed. The optional stall counter may be a small sat_counter instance if one exists. Otherwise inline.

Test Plan:
- CPU write alone: cpu_req=1, we=1, a=0x8000, d=0x41 with vid_req=0 → mem_we=1 at cycle 0, cpu_ack at cycle 2, later RAM read of 0x8000 returns 0x41.
- CPU read alone: RAM[0x8001]=0x17, cpu_req read a=0x8001 → cpu_ack at cycle 2 with cpu_q=0x17.
- Collision: vid_req=1, vid_a=0x8010 and cpu_req read 0x8002 in the same cycle → mem_a=0x8010, vid_q correct next cycle, CPU granted cycle +1, ack cycle +3.
- Scanout pattern: vid_req on x=5 and x=6 of every 8 with continuous CPU reads → every vid_q has 1-cycle latency, each CPU ack arrives ≤4 cycles after req, no data corruption over 640 pixels.
- Reset in WAIT: assert reset_n=0 for 1 cycle after grant → cpu_ack never pulses, FSM=IDLE, next request completes normally.
- VRAM_STALL_CNT_EN: 5 collision cycles → stall_cnt=5. stall_clr → 0. Forced 70000 collisions → saturates at 0xFFFF.
